// File: rtl/agu_pkg.sv
// agu_pkg: shared types, channel indices and canonical-address helper for the AGU
package agu_pkg;

    typedef enum logic [1:0] {SCALE1, SCALE2, SCALE4, SCALE8} agu_scale_e;

    localparam int CH_SRC1 = 0;
    localparam int CH_SRC2 = 1;
    localparam int CH_DEST = 2;

    // Widest address the canonical helper accepts; callers sign-extend into it.
    localparam int CANON_W = 128;

    // Canonical when every bit from va_bits-1 upward equals bit va_bits-1.
    function automatic logic isCanonical(input logic [CANON_W-1:0] addr, input int va_bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < CANON_W; i++)
            if (i >= va_bits && addr[i] != addr[va_bits-1]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/agu_channel.sv
// agu_channel: one address channel, stage-1 base/index/rip select and stage-2 disp add with canonical check
//   clk, resetN        clock, asynchronous active-low reset
//   s1_load, s2_load   stage register load strobes from the pipeline control
//   en, use_rip        channel enable and rip-relative select (stage-1 inputs)
//   index_valid, scale index present and log2 scale
//   rip, base, index   raw operands; disp is the stage-1 registered displacement
//   addr, addr_valid, non_canon  stage-2 results, zero when the channel is disabled
module agu_channel
    import agu_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int VA_BITS = 48
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              s1_load,
    input  logic              s2_load,
    input  logic              en,
    input  logic              use_rip,
    input  logic              index_valid,
    input  agu_scale_e        scale,
    input  logic [ADDR_W-1:0] rip,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] index,
    input  logic [ADDR_W-1:0] disp,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              non_canon
);
    logic [ADDR_W-1:0] partial;
    logic [ADDR_W-1:0] sum;
    logic              en_q;

    assign sum = partial + disp;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            partial    <= '0;
            en_q       <= 1'b0;
            addr       <= '0;
            addr_valid <= 1'b0;
            non_canon  <= 1'b0;
        end else begin
            if (s1_load) begin
                partial <= use_rip ? rip : base + (index_valid ? index << scale : '0);
                en_q    <= en;
            end
            if (s2_load) begin
                addr       <= en_q ? sum : '0;
                addr_valid <= en_q;
                non_canon  <= en_q && !isCanonical(CANON_W'($signed(sum)), VA_BITS);
            end
        end

endmodule

// File: rtl/agu_pipeline.sv
// agu_pipeline: two-stage valid/ready address-generation unit producing NUM_CH effective addresses per instruction
//   clk, resetN            clock, asynchronous active-low reset
//   flushIn                drop everything in flight and any same-cycle accept
//   inValid/inReady        upstream handshake; ripIn, dispIn, tagIn, ch*In operands
//   outValid/outReady      downstream handshake; addrOut, addrValidOut, nonCanonOut, tagOut results
module agu_pipeline
    import agu_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int VA_BITS = 48,
    parameter int NUM_CH  = 3,
    parameter int TAG_W   = 256
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     flushIn,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [ADDR_W-1:0]        ripIn,
    input  logic [ADDR_W-1:0]        dispIn,
    input  logic [TAG_W-1:0]         tagIn,
    input  logic [NUM_CH-1:0]        chEnIn,
    input  logic [NUM_CH-1:0]        chUseRipIn,
    input  logic [NUM_CH*ADDR_W-1:0] chBaseIn,
    input  logic [NUM_CH*ADDR_W-1:0] chIndexIn,
    input  logic [NUM_CH-1:0]        chIndexValidIn,
    input  logic [NUM_CH*2-1:0]      chScaleIn,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [NUM_CH*ADDR_W-1:0] addrOut,
    output logic [NUM_CH-1:0]        addrValidOut,
    output logic [NUM_CH-1:0]        nonCanonOut,
    output logic [TAG_W-1:0]         tagOut
);
    logic              s1_valid, s2_valid;
    logic              s1_adv, s2_adv;
    logic              s1_load, s2_load;
    logic [ADDR_W-1:0] disp_q;
    logic [TAG_W-1:0]  tag_q;

    // inReady depends only on pipeline state and outReady, never on inValid.
    assign s2_adv   = !s2_valid || outReady;
    assign s1_adv   = !s1_valid || s2_adv;
    assign inReady  = s1_adv;
    assign s1_load  = inValid && s1_adv;
    assign s2_load  = s1_valid && s2_adv;
    assign outValid = s2_valid;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            disp_q   <= '0;
            tag_q    <= '0;
            tagOut   <= '0;
        end else begin
            if (flushIn) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_adv) s1_valid <= inValid;
                if (s2_adv) s2_valid <= s1_valid;
            end
            if (s1_load) begin
                disp_q <= dispIn;
                tag_q  <= tagIn;
            end
            if (s2_load) tagOut <= tag_q;
        end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        agu_channel #(.ADDR_W(ADDR_W), .VA_BITS(VA_BITS)) u_ch (
            .clk        (clk),
            .resetN     (resetN),
            .s1_load    (s1_load),
            .s2_load    (s2_load),
            .en         (chEnIn[i]),
            .use_rip    (chUseRipIn[i]),
            .index_valid(chIndexValidIn[i]),
            .scale      (agu_scale_e'(chScaleIn[i*2 +: 2])),
            .rip        (ripIn),
            .base       (chBaseIn[i*ADDR_W +: ADDR_W]),
            .index      (chIndexIn[i*ADDR_W +: ADDR_W]),
            .disp       (disp_q),
            .addr       (addrOut[i*ADDR_W +: ADDR_W]),
            .addr_valid (addrValidOut[i]),
            .non_canon  (nonCanonOut[i])
        );
    end

endmodule
